// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding and small operation-class helpers.
package md_sequencer_pkg;

  localparam int MD_OP_WD = 3;

  localparam logic [MD_OP_WD-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [MD_OP_WD-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [MD_OP_WD-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [MD_OP_WD-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [MD_OP_WD-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [MD_OP_WD-1:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // True for the two multiply flavours.
  function automatic logic md_is_mul(input logic [MD_OP_WD-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

  // True for the two divide flavours.
  function automatic logic md_is_div(input logic [MD_OP_WD-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  // True for the operations that treat operands as two's complement.
  function automatic logic md_is_signed(input logic [MD_OP_WD-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// Iterative datapath shared by multiply and divide. One register pair
// (hi/lo) serves as the shift-add accumulator/multiplier for MUL and as the
// partial remainder/dividend-quotient shifter for DIV. Operands arrive as
// unsigned magnitudes; sign handling lives in the sequencer. The next-step
// values are exported so the sequencer can commit the final step directly.
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  // One shift-add or one restoring-divide step computed from the current registers.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (i_div) begin
      // A clear top bit of the difference means no borrow: remainder >= divisor.
      if (!w_diff[WIDTH]) begin
        o_hi_nxt = w_diff[WIDTH-1:0];
        o_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi_nxt = w_rem_sh[WIDTH-1:0];
        o_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_hi_nxt = w_sum[WIDTH:1];
      o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Load operands on start, otherwise advance one step when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
      r_b  <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      r_hi <= o_hi_nxt;
      r_lo <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. Accepts MULT/MULTU/
// DIV/DIVU/MTHI/MTLO from EX, runs WIDTH iterations in md_iter_unit while
// holding the pipeline, then commits the sign-corrected result.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                md_valid,
  input  logic [MD_OP_WD-1:0] md_op,
  input  logic [WIDTH-1:0]    md_src_a,
  input  logic [WIDTH-1:0]    md_src_b,
  output logic                stallreq_for_md,
  output logic                md_busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_stall;
  logic               w_last;
  logic               w_start;
  logic               w_step;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_last  = (r_cnt == CNT_LAST);
  assign w_start = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);
  assign w_step  = (r_state == ST_MUL) || (r_state == ST_DIV);

  // Next-state and stall request; the stall covers the accept cycle and all iterations.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_valid && md_is_mul(md_op)) begin
          w_state_nxt = ST_MUL;
          w_stall     = 1'b1;
        end else if (md_valid && md_is_div(md_op)) begin
          w_state_nxt = ST_DIV;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_stall = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_DIV: begin
        w_stall = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  always_comb begin
    w_a_neg = md_is_signed(md_op) & md_src_a[WIDTH-1];
    w_b_neg = md_is_signed(md_op) & md_src_b[WIDTH-1];
    w_mag_a = w_a_neg ? (~md_src_a + ONE_W) : md_src_a;
    w_mag_b = w_b_neg ? (~md_src_b + ONE_W) : md_src_b;
  end

  // Sign correction of the final step's magnitude result.
  always_comb begin
    w_prod     = {w_it_hi, w_it_lo};
    w_prod_fix = r_neg_q ? (~w_prod + ONE_2W) : w_prod;
    w_quo_fix  = r_neg_q ? (~w_it_lo + ONE_W) : w_it_lo;
    w_rem_fix  = r_neg_r ? (~w_it_hi + ONE_W) : w_it_hi;
  end

  md_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_div    (r_state == ST_DIV),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_hi_nxt (w_it_hi),
    .o_lo_nxt (w_it_lo)
  );

  // State register and registered busy flag (high whenever the next state is not IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Iteration counter: runs 0..WIDTH-1 while iterating, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_MUL, ST_DIV: r_cnt <= w_last ? CNT_ZERO : (r_cnt + CNT_ONE);
        default:        r_cnt <= CNT_ZERO;
      endcase
    end
  end

  // Result signs captured at accept: product/quotient negative iff signs differ, remainder follows dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

  // HI/LO: direct moves from IDLE, sign-corrected commit on the last iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (md_valid && (md_op == MD_OP_MTHI)) begin
            r_hi <= md_src_a;
          end else if (md_valid && (md_op == MD_OP_MTLO)) begin
            r_lo <= md_src_a;
          end
        end
        ST_MUL: begin
          if (w_last) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        ST_DIV: begin
          if (w_last) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stallreq_for_md = w_stall;
  assign md_busy         = r_busy;
  assign hi              = r_hi;
  assign lo              = r_lo;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the five-stage CPU pipeline. It sits beside EX: it accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the EX stage and runs a 32-step iterative shift-add or restoring-divide datapath. While an operation is in progress it holds the pipeline through the stall controller, then commits the result to HI/LO. HI and LO are exported to EX for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, default 32, operand and HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `md_valid`  in  1  EX holds a valid mul/div/mthi/mtlo instruction this cycle.
- `md_op`  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; encodings are in `defines.vh`.
- `md_src_a`  in  WIDTH  rs operand (forwarded value).
- `md_src_b`  in  WIDTH  rt operand (forwarded value).
- `stallreq_for_md`  out  1  request to hold IF/ID/EX; combinational.
- `md_busy`  out  1  sequencer is not IDLE; registered.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: waits for an operation.
  - MUL: one shift-add step per cycle; counter counts 0..WIDTH-1.
  - DIV: one restoring step per cycle; counter counts 0..WIDTH-1.
  - DONE: result is committed and the pipeline is released.
- IDLE with `md_valid`:
  - MULT/MULTU → MUL; DIV/DIVU → DIV.
  - Operands are latched in the same edge. Signed ops latch absolute values and record the sign of the result, or the signs of quotient and remainder.
- IDLE with MTHI/MTLO: `hi`/`lo` ← `md_src_a` at the edge. There is no stall and the state stays IDLE.
- MUL/DIV advance to DONE after counter == WIDTH-1. On that edge the HI/LO write occurs, sign-corrected:
  - MUL: HI = product[2W-1:W], LO = product[W-1:0].
  - DIV: LO = quotient, HI = remainder. The remainder takes the dividend's sign; the quotient is negative iff the operand signs differ.
- DONE → IDLE unconditionally after one cycle. During DONE the original instruction is still in EX, and it leaves EX at the end of DONE.
- `stallreq_for_md` = (IDLE & `md_valid` & op ∈ {MULT,MULTU,DIV,DIVU}) | MUL | DIV. It is 0 in DONE and for MTHI/MTLO.
- Divide by zero: divisor 0 completes normally in WIDTH cycles. Fixed result: LO = all-ones, HI = dividend (unsigned magnitude, then sign-corrected as for any divide).
- Signed edge case: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural wrap of magnitude arithmetic.
- Inputs are ignored outside IDLE.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, `hi` = `lo` = 0, `md_busy` = 0, `stallreq_for_md` = 0 when `md_valid` = 0.
- MTHI/MTLO: issued at cycle T, the new value is visible on `hi`/`lo` at T+1.
- MULT/DIV accepted at cycle T:
  - `stallreq_for_md` is high for T..T+WIDTH.
  - DONE occupies T+WIDTH+1.
  - HI/LO are valid from T+WIDTH+1.
  - The pipeline is held WIDTH+1 cycles in total (33 for WIDTH = 32).
- A mul/div immediately following in EX at T+WIDTH+2 is accepted from IDLE, so there is no bubble beyond the stall.
- `rst` asserted in MUL/DIV aborts the operation: the state is IDLE and HI/LO = 0 immediately. Nothing is committed.

## Structure
- `defines.vh`: `MD_OP_*` encodings and `MD_OP_WD`. Add an `MD_TO_EX_WD` bus width if HI/LO are bundled.
- Sub-module `md_iter_unit`: a pure datapath holding the shift/accumulate and partial-remainder registers, controlled by start/step/mode signals. The FSM, counter, sign fix-up and HI/LO stay in `md_sequencer`.
- The stall controller ORs `stallreq_for_md` into the existing stall bus.

## Test plan
- MTHI 0x12345678 then MTLO 0x9 → `hi` = 0x12345678, `lo` = 0x9 one cycle later each; `stallreq_for_md` never rises.
- MULT 0xFFFFFFFE × 3 → stall for 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. The same operands with MULTU → HI = 0x2, LO = 0xFFFFFFFA.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 0x55 / 0 → LO = 0xFFFFFFFF, HI = 0x55, with normal 33-cycle stall; DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- Back-to-back MULT then DIV → second op accepted the cycle after DONE; total stall 66 cycles; final HI/LO equal the DIV result.
- `rst` pulsed at iteration 10 of a DIV → outputs zero asynchronously; state IDLE; a subsequent MULTU 5 × 6 yields LO = 30, HI = 0.
